// File: rtl/saradc_11b_dig_sched_pkg.sv
// Shared types and default constants for the SAR ADC conversion scheduler.
package saradc_11b_dig_sched_pkg;

  localparam int NREQ_DFLT        = 4;
  localparam int CHNR_MSB_DFLT    = 4;
  localparam int RESULT_MSB_DFLT  = 10;
  localparam int TIMEOUT_CYC_DFLT = 255;

  typedef logic [2:0] sched_state_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_EOC  = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/saradc_11b_dig_rr_arb.sv
// Rotating-priority arbiter: first asserted request at or above rr_ptr_i, wrapping.
module saradc_11b_dig_rr_arb
  import saradc_11b_dig_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DFLT,
  localparam int PW  = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   rr_ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic            valid_o
);

  logic [PW-1:0] idx;

  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(rr_ptr_i) + i) % NREQ);
      if (!valid_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/saradc_11b_dig_conv_sched.sv
// Conversion scheduler for the 11-bit SAR ADC: arbitrates requesters, runs one conversion, acks.
// Optional eoc watchdog enabled by defining SARADC_11B_SCHED_TIMEOUT_EN.
//
// state        | meaning
// IDLE         | waiting for enabled, ready ADC and a request
// START        | one-cycle start_adc_o pulse
// WAIT_BUSY    | waiting for ADC to report busy (or an early eoc)
// WAIT_EOC     | conversion running, waiting for eoc
// ACK          | one-cycle ack to the granted requester with result/err
module saradc_11b_dig_conv_sched
  import saradc_11b_dig_sched_pkg::*;
#(
  parameter int NREQ        = NREQ_DFLT,
  parameter int CHNR_MSB    = CHNR_MSB_DFLT,
  parameter int RESULT_MSB  = RESULT_MSB_DFLT,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DFLT
) (
  input  logic                         clk_i,
  input  logic                         res_i,
  input  logic                         enable_i,
  input  logic [NREQ-1:0]              req_i,
  input  logic [NREQ*(CHNR_MSB+1)-1:0] req_chnr_i,
  output logic [NREQ-1:0]              ack_o,
  output logic [RESULT_MSB:0]          result_o,
  output logic                         err_o,
  input  logic                         mod_ready_i,
  input  logic                         busy_i,
  input  logic                         eoc_i,
  input  logic [RESULT_MSB:0]          result_i,
  output logic                         start_adc_o,
  output logic [CHNR_MSB:0]            chnr_o,
  output logic                         sched_busy_o
);

  localparam int CW = CHNR_MSB + 1;
  localparam int PW = ptr_width(NREQ);

  sched_state_t        state;
  logic [NREQ-1:0]     gnt_q;
  logic [NREQ-1:0]     arb_gnt;
  logic                arb_valid;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       gnt_idx;
  logic [PW-1:0]       rr_next;
  logic [CHNR_MSB:0]   chnr_q;
  logic [CHNR_MSB:0]   chnr_sel;
  logic [RESULT_MSB:0] res_q;
  logic                err_q;
  logic                in_wait;
  logic                tmo_hit;

  saradc_11b_dig_rr_arb #(.NREQ(NREQ)) u_arb (
    .req_i    (req_i),
    .rr_ptr_i (rr_ptr),
    .grant_o  (arb_gnt),
    .valid_o  (arb_valid)
  );

  always_comb begin
    chnr_sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (arb_gnt[i]) chnr_sel = req_chnr_i[i*CW +: CW];
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt_q[i]) gnt_idx = PW'(i);
  end

  assign rr_next = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
  assign in_wait = (state == ST_WAIT_BUSY) || (state == ST_WAIT_EOC);

`ifdef SARADC_11B_SCHED_TIMEOUT_EN
  // Down-counter reloaded in START; terminal count 1 means TIMEOUT_CYC wait cycles elapsed.
  logic [7:0] tmo_cnt;

  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i)                          tmo_cnt <= '0;
    else if (state == ST_START)         tmo_cnt <= 8'(TIMEOUT_CYC);
    else if (in_wait && tmo_cnt != '0)  tmo_cnt <= tmo_cnt - 8'd1;
  end

  assign tmo_hit = in_wait && (tmo_cnt == 8'd1);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      state  <= ST_IDLE;
      gnt_q  <= '0;
      chnr_q <= '0;
      rr_ptr <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable_i && mod_ready_i && arb_valid) begin
            gnt_q  <= arb_gnt;
            chnr_q <= chnr_sel;
            res_q  <= '0;
            err_q  <= 1'b0;
            state  <= ST_START;
          end
        end
        ST_START: begin
          if (!mod_ready_i) begin
            err_q <= 1'b1;
            res_q <= '0;
            state <= ST_ACK;
          end else begin
            state <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY, ST_WAIT_EOC: begin
          // Loss of module ready wins over a coincident eoc.
          if (!mod_ready_i || (tmo_hit && !eoc_i)) begin
            err_q <= 1'b1;
            res_q <= '0;
            state <= ST_ACK;
          end else if (eoc_i) begin
            res_q <= result_i;
            state <= ST_ACK;
          end else if (state == ST_WAIT_BUSY && busy_i) begin
            state <= ST_WAIT_EOC;
          end
        end
        ST_ACK: begin
          rr_ptr <= rr_next;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign start_adc_o  = (state == ST_START);
  assign ack_o        = (state == ST_ACK) ? gnt_q : '0;
  assign result_o     = (state == ST_ACK) ? res_q : '0;
  assign err_o        = (state == ST_ACK) ? err_q : 1'b0;
  assign chnr_o       = chnr_q;
  assign sched_busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_saradc_11b_dig_conv_sched.sv
// Self-checking bench for saradc_11b_dig_conv_sched: vector table plus corner-case sequences.
module tb_saradc_11b_dig_conv_sched;

  logic        clk_i = 1'b0;
  logic        res_i;
  logic        enable_i;
  logic [3:0]  req_i;
  logic [19:0] req_chnr_i;
  logic [3:0]  ack_o;
  logic [10:0] result_o;
  logic        err_o;
  logic        mod_ready_i;
  logic        busy_i;
  logic        eoc_i;
  logic [10:0] result_i;
  logic        start_adc_o;
  logic [4:0]  chnr_o;
  logic        sched_busy_o;

  saradc_11b_dig_conv_sched dut (
    .clk_i        (clk_i),
    .res_i        (res_i),
    .enable_i     (enable_i),
    .req_i        (req_i),
    .req_chnr_i   (req_chnr_i),
    .ack_o        (ack_o),
    .result_o     (result_o),
    .err_o        (err_o),
    .mod_ready_i  (mod_ready_i),
    .busy_i       (busy_i),
    .eoc_i        (eoc_i),
    .result_i     (result_i),
    .start_adc_o  (start_adc_o),
    .chnr_o       (chnr_o),
    .sched_busy_o (sched_busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  ack;
    logic [10:0] res;
    logic        err;
  } sb_t;

  typedef struct {
    logic [3:0]  req;
    logic [19:0] chnr;
    logic [10:0] res;
    logic        use_busy;
    logic        drop_ready;
    logic [3:0]  exp_ack;
    logic [4:0]  exp_chnr;
    logic [10:0] exp_res;
    logic        exp_err;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] ack, input logic [10:0] res, input logic err);
    sb_t e;
    e.ack = ack;
    e.res = res;
    e.err = err;
    sb_q.push_back(e);
  endtask

  task automatic wait_start(input int budget);
    int  i;
    logic ok;
    i  = 0;
    ok = 1'b0;
    while (!ok && i < budget) begin
      @(negedge clk_i);
      i++;
      if (start_adc_o) ok = 1'b1;
    end
    chk("start_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_ack(input int budget, output int cyc);
    sb_t e;
    int  i;
    i = 0;
    while (ack_o == 4'd0 && i < budget) begin
      @(negedge clk_i);
      i++;
    end
    cyc = i;
    if (ack_o == 4'd0) begin
      n_checks++;
      n_errs++;
      $display("FAIL ack_timeout: actual=no ack required=ack within %0d cycles", budget);
    end else if (sb_q.size() == 0) begin
      n_checks++;
      n_errs++;
      $display("FAIL ack_unexpected: actual=%0h required=no ack", ack_o);
    end else begin
      e = sb_q.pop_front();
      chk("ack_vec", 32'(ack_o), 32'(e.ack));
      chk("ack_result", 32'(result_o), 32'(e.res));
      chk("ack_err", 32'(err_o), 32'(e.err));
    end
  endtask

  // Entered at the negedge of the START cycle; leaves at the negedge of the ACK cycle.
  task automatic conv_body(input logic use_busy, input logic drop_ready, input logic scramble,
                           input logic [10:0] res, input logic [4:0] exp_chnr);
    int cyc;
    chk("start_pulse", 32'(start_adc_o), 32'd1);
    chk("chnr_start", 32'(chnr_o), 32'(exp_chnr));
    if (scramble) begin
      req_i      = 4'd0;
      req_chnr_i = ~req_chnr_i;
    end
    busy_i = use_busy;
    @(negedge clk_i);
    chk("start_one_cycle", 32'(start_adc_o), 32'd0);
    if (use_busy) @(negedge clk_i);
    busy_i   = 1'b0;
    eoc_i    = 1'b1;
    result_i = res;
    if (drop_ready) mod_ready_i = 1'b0;
    chk("chnr_hold", 32'(chnr_o), 32'(exp_chnr));
    @(negedge clk_i);
    eoc_i       = 1'b0;
    result_i    = '0;
    mod_ready_i = 1'b1;
    wait_ack(4, cyc);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ack"}, 32'(ack_o), 32'd0);
    chk({tag, "_result"}, 32'(result_o), 32'd0);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
    chk({tag, "_busy"}, 32'(sched_busy_o), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk_i);
    res_i = 1'b1;
    @(negedge clk_i);
    res_i = 1'b0;
  endtask

  initial begin
    int   cyc;
    int   seen;
    logic busy_all;

    vecs[0] = '{req: 4'b1010, chnr: {5'd0, 5'd0, 5'd5, 5'd0}, res: 11'h2A5, use_busy: 1'b1,
                drop_ready: 1'b0, exp_ack: 4'b0010, exp_chnr: 5'd5, exp_res: 11'h2A5, exp_err: 1'b0};
    vecs[1] = '{req: 4'b1111, chnr: {5'd31, 5'd9, 5'd7, 5'd3}, res: 11'h123, use_busy: 1'b0,
                drop_ready: 1'b0, exp_ack: 4'b0100, exp_chnr: 5'd9, exp_res: 11'h123, exp_err: 1'b0};
    vecs[2] = '{req: 4'b0001, chnr: {5'd1, 5'd2, 5'd3, 5'd17}, res: 11'h7FF, use_busy: 1'b1,
                drop_ready: 1'b0, exp_ack: 4'b0001, exp_chnr: 5'd17, exp_res: 11'h7FF, exp_err: 1'b0};
    vecs[3] = '{req: 4'b0001, chnr: {5'd9, 5'd9, 5'd9, 5'd2}, res: 11'h3C3, use_busy: 1'b1,
                drop_ready: 1'b1, exp_ack: 4'b0001, exp_chnr: 5'd2, exp_res: 11'h000, exp_err: 1'b1};
    vecs[4] = '{req: 4'b1001, chnr: {5'd30, 5'd4, 5'd4, 5'd1}, res: 11'h000, use_busy: 1'b0,
                drop_ready: 1'b0, exp_ack: 4'b1000, exp_chnr: 5'd30, exp_res: 11'h000, exp_err: 1'b0};
    vecs[5] = '{req: 4'b0110, chnr: {5'd0, 5'd8, 5'd4, 5'd0}, res: 11'h555, use_busy: 1'b1,
                drop_ready: 1'b0, exp_ack: 4'b0010, exp_chnr: 5'd4, exp_res: 11'h555, exp_err: 1'b0};

    // Reset with active inputs: everything must hold at zero.
    res_i       = 1'b1;
    enable_i    = 1'b1;
    mod_ready_i = 1'b1;
    req_i       = 4'b1111;
    req_chnr_i  = 20'hFFFFF;
    busy_i      = 1'b0;
    eoc_i       = 1'b0;
    result_i    = 11'h7FF;
    repeat (3) @(negedge clk_i);
    chk("rst_start", 32'(start_adc_o), 32'd0);
    chk("rst_chnr", 32'(chnr_o), 32'd0);
    check_idle("rst");
    req_i      = 4'd0;
    req_chnr_i = '0;
    result_i   = '0;
    res_i      = 1'b0;
    @(negedge clk_i);

    for (int v = 0; v < 6; v++) begin
      req_i      = vecs[v].req;
      req_chnr_i = vecs[v].chnr;
      push_exp(vecs[v].exp_ack, vecs[v].exp_res, vecs[v].exp_err);
      @(negedge clk_i);
      conv_body(vecs[v].use_busy, vecs[v].drop_ready, 1'b1, vecs[v].res, vecs[v].exp_chnr);
      @(negedge clk_i);
      check_idle("post_ack");
    end

    // All requesters held: grants rotate 0,1,2,3,0.
    pulse_reset();
    req_chnr_i = {5'd13, 5'd12, 5'd11, 5'd10};
    req_i      = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      push_exp(4'(1 << (k % 4)), 11'(100 + k), 1'b0);
      wait_start(4);
      conv_body(1'b1, 1'b0, 1'b0, 11'(100 + k), 5'(10 + (k % 4)));
    end
    req_i = 4'd0;
    @(negedge clk_i);

    // A request that vanishes before a grant is possible produces nothing.
    enable_i   = 1'b0;
    req_i      = 4'b0100;
    busy_all   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      busy_all |= start_adc_o | sched_busy_o;
    end
    req_i    = 4'd0;
    enable_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      busy_all |= start_adc_o | sched_busy_o;
    end
    chk("dropped_req_no_start", 32'(busy_all), 32'd0);

    // Disabled with requests pending: no start until enabled.
    enable_i   = 1'b0;
    req_i      = 4'b1111;
    busy_all   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      busy_all |= start_adc_o;
    end
    chk("disabled_no_start", 32'(busy_all), 32'd0);
    enable_i = 1'b1;
    push_exp(4'b0010, 11'h0F0, 1'b0);
    wait_start(3);
    enable_i = 1'b0;
    conv_body(1'b1, 1'b0, 1'b1, 11'h0F0, 5'd11);
    enable_i = 1'b1;
    @(negedge clk_i);

    // Reset mid-conversion drops it silently.
    req_chnr_i = {5'd13, 5'd12, 5'd11, 5'd10};
    req_i      = 4'b0100;
    wait_start(3);
    req_i  = 4'd0;
    busy_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("mid_busy", 32'(sched_busy_o), 32'd1);
    #2 res_i = 1'b1;
    #1;
    chk("rst_mid_start", 32'(start_adc_o), 32'd0);
    chk("rst_mid_chnr", 32'(chnr_o), 32'd0);
    check_idle("rst_mid");
    @(negedge clk_i);
    res_i  = 1'b0;
    busy_i = 1'b0;
    eoc_i  = 1'b1;
    result_i = 11'h1AB;
    @(negedge clk_i);
    eoc_i    = 1'b0;
    result_i = '0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (ack_o != 4'd0) seen++;
    end
    chk("rst_mid_no_ack", 32'(seen), 32'd0);

    // Stuck busy, no eoc.
    req_i = 4'b0100;
    wait_start(3);
    req_i  = 4'd0;
    busy_i = 1'b1;
`ifdef SARADC_11B_SCHED_TIMEOUT_EN
    push_exp(4'b0100, 11'h000, 1'b1);
    wait_ack(300, cyc);
    chk("tmo_latency", 32'(cyc), 32'd256);
    busy_i = 1'b0;
    @(negedge clk_i);
    check_idle("tmo_post");
`else
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_i);
      if (ack_o != 4'd0) seen++;
    end
    chk("no_tmo_ack", 32'(seen), 32'd0);
    chk("no_tmo_busy", 32'(sched_busy_o), 32'd1);
    busy_i = 1'b0;
    pulse_reset();
    check_idle("no_tmo_post");
`endif

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/saradc_11b_dig_conv_sched.md
SARADC_11B_DIG_CONV_SCHED -- requirements
Module: saradc_11b_dig_conv_sched

Interface
REQ-001 Parameter NREQ, default 4: number of conversion requesters (2..8).
REQ-002 Parameter CHNR_MSB, default 4: MSB of the channel number.
REQ-003 Parameter RESULT_MSB, default 10: MSB of the conversion result.
REQ-004 Parameter TIMEOUT_CYC, default 255: maximum cycles to wait for eoc (8-bit counter).
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset; ports clk_i and res_i.
REQ-006 clk_i  input  1  system clock, all state updates on rising edge.
REQ-007 res_i  input  1  asynchronous active-high reset.
REQ-008 enable_i  input  1  scheduler enable; low blocks new grants.
REQ-009 req_i  input  NREQ  per-requester conversion request level.
REQ-010 req_chnr_i  input  NREQ*(CHNR_MSB+1)  packed channel number per requester, slot k at bits [k*(CHNR_MSB+1) +: CHNR_MSB+1].
REQ-011 ack_o  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-012 result_o  output  RESULT_MSB+1  result, valid only while any ack_o bit is high.
REQ-013 err_o  output  1  error flag, valid with ack_o.
REQ-014 mod_ready_i  input  1  ADC module ready (startup complete).
REQ-015 busy_i / eoc_i  input  1 each  ADC conversion busy level / end-of-conversion pulse.
REQ-016 result_i  input  RESULT_MSB+1  ADC result, valid when eoc_i high.
REQ-017 start_adc_o  output  1  one-cycle conversion start pulse.
REQ-018 chnr_o  output  CHNR_MSB+1  channel for the ongoing conversion.
REQ-019 sched_busy_o  output  1  high in every state except IDLE.

Function
REQ-020 FSM states IDLE, START, WAIT_BUSY, WAIT_EOC, ACK.
REQ-021 IDLE: if enable_i & mod_ready_i & |req_i, grant the first requester with req_i set searching upward from rr_ptr (wrapping), latch its channel into chnr_o, go START.
REQ-022 START: start_adc_o=1 for exactly one cycle, go WAIT_BUSY; request at cycle n yields start_adc_o at n+1.
REQ-023 WAIT_BUSY: on busy_i or eoc_i go WAIT_EOC; an eoc_i seen here SHALL be handled as in REQ-024 in the same cycle.
REQ-024 WAIT_EOC: on eoc_i capture result_i, go ACK; ack_o at cycle m+1 for eoc_i at cycle m.
REQ-025 ACK: ack_o[grant]=1 for one cycle with result_o, err_o; rr_ptr = (grant+1) mod NREQ; go IDLE.
REQ-026 chnr_o SHALL stay constant from START through ACK; changes of req_i/req_chnr_i after grant are ignored.
REQ-027 Requester dropping req_i before grant: no grant, no ack.
REQ-028 mod_ready_i low in START/WAIT_BUSY/WAIT_EOC: abort to ACK with err_o=1, result_o=0; simultaneous eoc_i loses to abort.
REQ-029 enable_i low mid-conversion SHALL NOT abort; conversion completes normally.
REQ-030 result_o and err_o SHALL be 0 outside ACK.

Reset
REQ-031 res_i high: state IDLE, rr_ptr=0, all outputs 0, timeout counter 0; reset mid-conversion drops the conversion without ack.

Configuration
REQ-032 Macro SARADC_11B_SCHED_TIMEOUT_EN defined: counter runs in WAIT_BUSY/WAIT_EOC; reaching TIMEOUT_CYC without eoc_i forces ACK with err_o=1, result_o=0; counter clears on entering START.
REQ-033 Macro undefined: no counter; scheduler waits indefinitely, err_o only from REQ-028.

Structure
REQ-034 Package saradc_11b_dig_sched_pkg SHALL hold the state enum and default constants (NREQ, TIMEOUT_CYC).
REQ-035 Sub-module saradc_11b_dig_rr_arb: combinational rotating-priority arbiter (req, rr_ptr -> one-hot grant, valid).

Verification
REQ-036 req_i=4'b1010, rr_ptr=0, chnr slot1=5 -> start_adc_o pulse next cycle, chnr_o=5; eoc_i with result_i=0x2A5 -> ack_o=4'b0010, result_o=0x2A5 next cycle.
REQ-037 req_i=4'b1111 held through 4 conversions -> grant order 0,1,2,3, then 0.
REQ-038 mod_ready_i dropped in WAIT_EOC -> ack_o pulse with err_o=1, result_o=0, state IDLE.
REQ-039 With SARADC_11B_SCHED_TIMEOUT_EN, busy_i stuck 1 without eoc_i -> err ack after 255 cycles; without macro no ack after 1000 cycles.
REQ-040 res_i asserted in WAIT_EOC -> all outputs 0 immediately, no ack; enable_i=0 with req_i set -> no start_adc_o.
